// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Imported by the TX FIFO and the TX engine.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO that queues bytes waiting for the serialiser.
// dout always shows the head entry whenever empty is low.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; only the pointers and count do, so an
  // empty FIFO never exposes stale entries and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter: write FIFO, 16x oversample baud divider, frame FSM and
// a registered serial output that idles high.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tx_wen,
  input  logic [DATA_W-1:0]               tx_din,
  output logic                            tx,
  output logic                            tx_full,
  output logic                            tx_empty,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_count,
  output logic                            tx_overflow,
  input  logic                            ovf_clr
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  tx_state_t         state;
  tx_state_t         state_next;
  logic              pop;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  bit_idx;
  logic [DIV_W-1:0]  div_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              bit_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wen),
    .pop   (pop),
    .din   (tx_din),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  assign tick    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_end = tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
  assign tx_busy = (state != IDLE);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!tx_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == IDX_W'(DATA_W - 1))) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!tx_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        shift_reg <= fifo_dout;
        bit_idx   <= '0;
      end else if ((state == DATA) && bit_end) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= bit_idx + IDX_W'(1);
      end
    end
  end

  // Timing restarts at every frame so each bit is exactly OVERSAMPLE*CLK_DIV clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if ((state == IDLE) || pop) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      tick_cnt <= tick_cnt + TICK_W'(1);
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // The line flop follows the state/shift flops one clock later, keeping tx glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx <= 1'b1;
    end else begin
      unique case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift_reg[0];
        default: tx <= 1'b1;
      endcase
    end
  end

  // A push refused while full sets the flag even when ovf_clr is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_overflow <= 1'b0;
    end else if (tx_wen && tx_full) begin
      tx_overflow <= 1'b1;
    end else if (ovf_clr) begin
      tx_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a CLK_DIV=27 instance for timing-exact
// frame checks and a CLK_DIV=1 instance for a randomised scoreboard run.
module tb_uart_tx_engine;

  localparam int BIT_SLOW = 16 * 27;
  localparam int BIT_FAST = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       tx_wen = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       tx, tx_full, tx_empty, tx_busy, tx_overflow;
  logic [4:0] tx_count;

  logic       tx_wen_f = 1'b0;
  logic [7:0] tx_din_f = 8'h00;
  logic       ovf_clr_f = 1'b0;
  logic       tx_f, tx_full_f, tx_empty_f, tx_busy_f, tx_overflow_f;
  logic [4:0] tx_count_f;

  logic       sel_fast = 1'b0;
  int         bit_len = BIT_SLOW;
  logic       cur_tx;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  logic [7:0] exp_q [$];

  assign cur_tx = sel_fast ? tx_f : tx;

  uart_tx_engine #(.CLK_DIV(27), .FIFO_DEPTH(16), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .tx_wen(tx_wen), .tx_din(tx_din), .tx(tx),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
    .tx_count(tx_count), .tx_overflow(tx_overflow), .ovf_clr(ovf_clr)
  );

  uart_tx_engine #(.CLK_DIV(1), .FIFO_DEPTH(16), .DATA_W(8)) dut_fast (
    .clk(clk), .rst(rst), .tx_wen(tx_wen_f), .tx_din(tx_din_f), .tx(tx_f),
    .tx_full(tx_full_f), .tx_empty(tx_empty_f), .tx_busy(tx_busy_f),
    .tx_count(tx_count_f), .tx_overflow(tx_overflow_f), .ovf_clr(ovf_clr_f)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed timeout expected line activity", tag);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    tx_din = b;
    tx_wen = 1'b1;
    step();
    tx_wen = 1'b0;
  endtask

  // Steps until the selected line is low; n is clocks waited.
  task automatic wait_fall(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b1;
    while (cur_tx !== 1'b0) begin
      if (n >= limit) begin
        ok = 1'b0;
        break;
      end
      step();
      n++;
    end
  endtask

  // Steps while the line holds level; n is the run length in clocks.
  task automatic measure_run(input logic level, input int limit, output int n);
    n = 0;
    while ((cur_tx === level) && (n < limit)) begin
      step();
      n++;
    end
  endtask

  // Decodes one frame by sampling mid-bit; returns at the middle of the stop bit.
  task automatic recv_frame(input string tag, input int limit, output logic [7:0] data, output int lat);
    bit ok;
    data = 8'hxx;
    wait_fall(limit, lat, ok);
    if (!ok) begin
      timeout(tag);
      return;
    end
    repeat (bit_len / 2) step();
    check({tag, "_start"}, cur_tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (bit_len) step();
      data[i] = cur_tx;
    end
    repeat (bit_len) step();
    check({tag, "_stop"}, cur_tx, 1'b1);
  endtask

  initial begin
    int         n;
    int         lat;
    int         fall_cyc;
    bit         ok;
    logic [7:0] d;
    logic       lvl;

    // 1. Reset
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_empty", tx_empty, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_count", tx_count, 5'd0);
    check("rst_full", tx_full, 1'b0);
    check("rst_ovf", tx_overflow, 1'b0);
    rst = 1'b1;
    repeat (3) step();

    // 2. Single 0x55 frame: every bit alternates, so each run must be one bit long
    push(8'h55);
    check("single_count", tx_count, 5'd1);
    wait_fall(20, lat, ok);
    check("single_latency", lat, 2);
    check("single_busy", tx_busy, 1'b1);
    lvl = 1'b0;
    for (int i = 0; i < 9; i++) begin
      measure_run(lvl, 2 * BIT_SLOW, n);
      check($sformatf("single_run%0d", i), n, BIT_SLOW);
      lvl = ~lvl;
    end
    check("single_stop_level", tx, 1'b1);
    repeat (BIT_SLOW - 2) step();
    check("single_busy_stop", tx_busy, 1'b1);
    repeat (2) step();
    check("single_busy_end", tx_busy, 1'b0);
    check("single_empty_end", tx_empty, 1'b1);
    repeat (10) step();
    check("single_idle_tx", tx, 1'b1);

    // 3. Back-to-back frames
    tx_wen = 1'b1;
    tx_din = 8'hA5;
    step();
    check("b2b_count0", tx_count, 5'd1);
    tx_din = 8'h00;
    step();
    check("b2b_count1", tx_count, 5'd1);
    tx_din = 8'hFF;
    step();
    tx_wen = 1'b0;
    check("b2b_count2", tx_count, 5'd2);
    recv_frame("b2b_f0", 20, d, lat);
    check("b2b_lat0", lat, 0);
    check("b2b_data0", d, 8'hA5);
    check("b2b_count3", tx_count, 5'd2);
    recv_frame("b2b_f1", 2 * BIT_SLOW, d, lat);
    check("b2b_gap1", lat, BIT_SLOW / 2);
    check("b2b_data1", d, 8'h00);
    recv_frame("b2b_f2", 2 * BIT_SLOW, d, lat);
    check("b2b_gap2", lat, BIT_SLOW / 2);
    check("b2b_data2", d, 8'hFF);
    repeat (BIT_SLOW / 2 + 4) step();
    check("b2b_busy_end", tx_busy, 1'b0);
    check("b2b_empty_end", tx_empty, 1'b1);

    // 4. Overflow: 0x11 in flight, then 17 more pushes into 16 slots
    push(8'h11);
    wait_fall(20, lat, ok);
    check("ovf_latency", lat, 2);
    fall_cyc = cyc;
    for (int i = 0; i < 17; i++) begin
      tx_din = 8'hB0 + 8'(i);
      tx_wen = 1'b1;
      step();
      if (i == 14) check("ovf_not_full15", tx_full, 1'b0);
      if (i == 15) begin
        check("ovf_full16", tx_full, 1'b1);
        check("ovf_flag_before", tx_overflow, 1'b0);
      end
    end
    tx_wen = 1'b0;
    check("ovf_full", tx_full, 1'b1);
    check("ovf_count", tx_count, 5'd16);
    check("ovf_flag", tx_overflow, 1'b1);
    tx_wen  = 1'b1;
    ovf_clr = 1'b1;
    step();
    tx_wen = 1'b0;
    check("ovf_set_wins", tx_overflow, 1'b1);
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", tx_overflow, 1'b0);
    check("ovf_count_kept", tx_count, 5'd16);

    // 5. Reset in the middle of data bit 3 (a 0 for 0x11)
    while (cyc < fall_cyc + 4 * BIT_SLOW + BIT_SLOW / 2) step();
    check("midrst_line_low", tx, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_empty", tx_empty, 1'b1);
    check("midrst_count", tx_count, 5'd0);
    check("midrst_full", tx_full, 1'b0);
    check("midrst_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) step();
    check("midrst_idle_tx", tx, 1'b1);
    push(8'h3C);
    recv_frame("post_rst", 20, d, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", d, 8'h3C);
    repeat (BIT_SLOW / 2 + 4) step();
    check("post_rst_busy", tx_busy, 1'b0);
    check("post_rst_empty", tx_empty, 1'b1);

    // 6. CLK_DIV=1 scoreboard run
    sel_fast = 1'b1;
    bit_len  = BIT_FAST;
    fork
      begin
        for (int k = 0; k < 64; k++) begin
          repeat ($urandom_range(0, 12)) step();
          while (tx_full_f === 1'b1) step();
          tx_din_f = 8'($urandom);
          exp_q.push_back(tx_din_f);
          tx_wen_f = 1'b1;
          step();
          tx_wen_f = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 64; k++) begin
          recv_frame($sformatf("fast_f%0d", k), 4000, d, lat);
          if (k < exp_q.size()) check($sformatf("fast_data%0d", k), d, exp_q[k]);
          else timeout($sformatf("fast_order%0d", k));
        end
      end
    join
    repeat (BIT_FAST) step();
    check("fast_overflow", tx_overflow_f, 1'b0);
    check("fast_empty", tx_empty_f, 1'b1);
    check("fast_busy", tx_busy_f, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
